// File: rtl/vga_text_fetch_pkg.sv
// ---- vga_text_fetch_pkg : shared defaults, fetch states, sizing helpers (rev 1.0) ----
`default_nettype none

package vga_text_fetch_pkg;

  localparam int unsigned ASCII_SIZE_DEF = 8;
  localparam int unsigned CHARS_HORZ_DEF = 80;
  localparam int unsigned CHARS_VERT_DEF = 30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    UNPACK = 2'd2,
    DONE   = 2'd3
  } fetch_state_t;

  function automatic int unsigned chars_per_word(input int unsigned ws, input int unsigned as);
    return ws / as;
  endfunction

  function automatic int unsigned words_for(input int unsigned total, input int unsigned cpw);
    return (total + cpw - 1) / cpw;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_text_fetch_char_ram.sv
// ---- vga_text_fetch_char_ram : screen char store, 1 write + 1 registered read (rev 1.0) ----
`default_nettype none

module vga_text_fetch_char_ram #(
  parameter int unsigned ASCII_SIZE = 8,
  parameter int unsigned CHARS_HORZ = 80,
  parameter int unsigned CHARS_VERT = 30,
  parameter int unsigned ROW_W      = 5,
  parameter int unsigned COL_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ROW_W-1:0]      i_wrow,
  input  logic [COL_W-1:0]      i_wcol,
  input  logic [ASCII_SIZE-1:0] i_wdata,
  input  logic [ROW_W-1:0]      i_rrow,
  input  logic [COL_W-1:0]      i_rcol,
  output logic [ASCII_SIZE-1:0] o_rdata
);

  logic [ASCII_SIZE-1:0] r_mem [CHARS_VERT][CHARS_HORZ];
  logic [ASCII_SIZE-1:0] r_rdata;
  logic                  w_rd_ok;

  assign w_rd_ok = (32'(i_rrow) < CHARS_VERT) && (32'(i_rcol) < CHARS_HORZ);

  // Contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wrow][i_wcol] <= i_wdata;
    end
  end

  // Same-cycle read of a cell being written returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_ok) begin
      r_rdata <= r_mem[i_rrow][i_rcol];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/vga_text_fetch.sv
// ---- vga_text_fetch : per-frame char fetch from memory into char RAM (rev 1.0) ----
// Build option: VGA_FETCH_LSB_FIRST_EN unpacks chars LSB-first instead of MSB-first.
`default_nettype none

module vga_text_fetch
  import vga_text_fetch_pkg::*;
#(
  parameter int unsigned          WORD_SIZE  = 32,
  parameter int unsigned          ASCII_SIZE = ASCII_SIZE_DEF,
  parameter int unsigned          CHARS_HORZ = CHARS_HORZ_DEF,
  parameter int unsigned          CHARS_VERT = CHARS_VERT_DEF,
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR  = '0,
  localparam int unsigned         ROW_W      = clog2_min1(CHARS_VERT),
  localparam int unsigned         COL_W      = clog2_min1(CHARS_HORZ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_valid,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic [ROW_W-1:0]      rd_row,
  input  logic [COL_W-1:0]      rd_col,
  output logic [ASCII_SIZE-1:0] rd_char,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned CPW   = chars_per_word(WORD_SIZE, ASCII_SIZE);
  localparam int unsigned TOTAL = CHARS_HORZ * CHARS_VERT;
  localparam int unsigned WORDS = words_for(TOTAL, CPW);
  localparam int unsigned K_W   = clog2_min1(CPW);
  localparam int unsigned WI_W  = clog2_min1(WORDS);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_REQ    = REQ;
  localparam logic [1:0] S_UNPACK = UNPACK;
  localparam logic [1:0] S_DONE   = DONE;

  generate
    if ((WORD_SIZE % ASCII_SIZE) != 0) begin : g_bad_word_size
      $error("vga_text_fetch: WORD_SIZE must be a multiple of ASCII_SIZE");
    end
  endgenerate

  logic [1:0]            r_state;
  logic                  r_req;
  logic [ADDR_W-1:0]     r_addr;
  logic [WORD_SIZE-1:0]  r_word;
  logic [K_W-1:0]        r_k;
  logic [WI_W-1:0]       r_widx;
  logic [ROW_W-1:0]      r_row;
  logic [COL_W-1:0]      r_col;
  logic                  r_full;
  logic                  r_overrun;

  logic [ASCII_SIZE-1:0] w_char;
  logic [WORD_SIZE-1:0]  w_word_next;
  logic                  w_we;
  logic                  w_last_k;
  logic                  w_last_word;
  logic                  w_col_wrap;
  logic                  w_row_last;

`ifdef VGA_FETCH_LSB_FIRST_EN
  assign w_char      = r_word[ASCII_SIZE-1:0];
  assign w_word_next = r_word >> ASCII_SIZE;
`else
  assign w_char      = r_word[WORD_SIZE-1 -: ASCII_SIZE];
  assign w_word_next = r_word << ASCII_SIZE;
`endif

  // r_full marks that the last screen cell is written; padding chars of the final word are dropped.
  assign w_we        = (r_state == S_UNPACK) && !r_full;
  assign w_last_k    = (r_k == K_W'(CPW - 1));
  assign w_last_word = (r_widx == WI_W'(WORDS - 1));
  assign w_col_wrap  = (r_col == COL_W'(CHARS_HORZ - 1));
  assign w_row_last  = (r_row == ROW_W'(CHARS_VERT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_addr    <= BASE_ADDR;
      r_word    <= '0;
      r_k       <= '0;
      r_widx    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (frame_start && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= BASE_ADDR;
            r_widx  <= '0;
            r_k     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_full  <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_valid) begin
            r_word  <= mem_rdata;
            r_req   <= 1'b0;
            r_k     <= '0;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_word <= w_word_next;
          r_k    <= r_k + 1'b1;
          if (!r_full) begin
            if (w_col_wrap) begin
              r_col <= '0;
              if (w_row_last) begin
                r_full <= 1'b1;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
          if (w_last_k) begin
            r_k <= '0;
            if (w_last_word) begin
              r_state <= S_DONE;
            end else begin
              r_widx  <= r_widx + 1'b1;
              r_addr  <= r_addr + 1'b1;
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  vga_text_fetch_char_ram #(
    .ASCII_SIZE (ASCII_SIZE),
    .CHARS_HORZ (CHARS_HORZ),
    .CHARS_VERT (CHARS_VERT),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W)
  ) u_char_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_wrow  (r_row),
    .i_wcol  (r_col),
    .i_wdata (w_char),
    .i_rrow  (rd_row),
    .i_rcol  (rd_col),
    .o_rdata (rd_char)
  );

  assign mem_req    = r_req;
  assign mem_addr   = r_addr;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign overrun    = r_overrun;

endmodule

`default_nettype wire
